// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared types and constants for the UART receive engine.
//  Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP1    = 3'd4,
        ST_STOP2    = 3'd5,
        ST_BRK_WAIT = 3'd6
    } rx_state_t;

    localparam logic [1:0] c_par_even   = 2'b00;
    localparam logic [1:0] c_par_odd    = 2'b01;
    localparam logic [1:0] c_par_stick1 = 2'b10;
    localparam logic [1:0] c_par_stick0 = 2'b11;

    localparam int c_stat_brk = 2;
    localparam int c_stat_frm = 1;
    localparam int c_stat_par = 0;

    localparam logic [3:0] c_tick_s0   = 4'd7;
    localparam logic [3:0] c_tick_s1   = 4'd8;
    localparam logic [3:0] c_tick_s2   = 4'd9;
    localparam logic [3:0] c_tick_last = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Out-of-range lengths saturate rather than wrap.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < 4'd5)
            return 4'd5;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Brief    : RXD synchroniser, per-bit tick counter and 3-sample majority.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic baud_clk_16x,
    input  logic reset_n,
    input  logic si,
    input  logic start,
    input  logic active,
    output logic sync_si,
    output logic bit_val,
    output logic bit_done
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_tick;
    logic                   r_s0;
    logic                   r_s1;

    always_ff @(posedge baud_clk_16x or negedge reset_n) begin
        if (!reset_n)
            r_sync <= '1;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], si};
    end

    assign sync_si = r_sync[SYNC_STAGES-1];

    // The start-detect cycle is tick 0, so the counter lands on 1 after it.
    always_ff @(posedge baud_clk_16x or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= 4'd0;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
        end else begin
            if (start)
                r_tick <= 4'd1;
            else if (active)
                r_tick <= (r_tick == c_tick_last) ? 4'd0 : r_tick + 4'd1;
            else
                r_tick <= 4'd0;

            if (active && r_tick == c_tick_s0)
                r_s0 <= sync_si;
            if (active && r_tick == c_tick_s1)
                r_s1 <= sync_si;
        end
    end

    assign bit_val  = majority3(r_s0, r_s1, sync_si);
    assign bit_done = active && (r_tick == c_tick_s2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Brief    : UART receive engine: 5..DW_MAX data bits, parity, 1/2 stop,
//             break detection and overrun reporting into the RX FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DW_MAX      = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic              baud_clk_16x,
    input  logic              reset_n,
    input  logic              cfg_rx_enable,
    input  logic [3:0]        cfg_data_len,
    input  logic [2:0]        cfg_parity,
    input  logic              cfg_stop_bit,
    input  logic              si,
    input  logic              fifo_aval,
    output logic              fifo_wr,
    output logic [DW_MAX-1:0] fifo_data,
    output logic [2:0]        fifo_stat,
    output logic              overrun,
    output logic              rx_busy
);

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic              w_sync_si;
    logic              w_bit_val;
    logic              w_bit_done;
    logic              w_active;
    logic              w_start;
    logic              w_complete;
    logic              w_exp_par;
    logic              w_frm_final;
    logic              w_brk_final;

    logic [3:0]        r_len;
    logic              r_par_en;
    logic [1:0]        r_par_mode;
    logic              r_two_stop;
    logic [3:0]        r_bit_cnt;
    logic [DW_MAX-1:0] r_data;
    logic              r_par_err;
    logic              r_frm_err;
    logic              r_all_zero;

    assign w_active = (r_state != ST_IDLE) && (r_state != ST_BRK_WAIT);
    assign rx_busy  = (r_state != ST_IDLE);

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .baud_clk_16x (baud_clk_16x),
        .reset_n      (reset_n),
        .si           (si),
        .start        (w_start),
        .active       (w_active),
        .sync_si      (w_sync_si),
        .bit_val      (w_bit_val),
        .bit_done     (w_bit_done)
    );

    always_comb begin
        w_exp_par = 1'b0;
        case (r_par_mode)
            c_par_even:   w_exp_par = ^r_data;
            c_par_odd:    w_exp_par = ~(^r_data);
            c_par_stick1: w_exp_par = 1'b1;
            c_par_stick0: w_exp_par = 1'b0;
            default:      w_exp_par = 1'b0;
        endcase
    end

    // Status as it will stand once the stop bit currently being resolved lands.
    assign w_frm_final = r_frm_err | ~w_bit_val;
    assign w_brk_final = r_all_zero & ~w_bit_val;

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_rx_enable && !w_sync_si) begin
                    w_start = 1'b1;
                    w_next  = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done)
                    w_next = w_bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done && r_bit_cnt == r_len - 4'd1)
                    w_next = r_par_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (w_bit_done)
                    w_next = ST_STOP1;
            end
            ST_STOP1: begin
                if (w_bit_done) begin
                    if (r_two_stop) begin
                        w_next = ST_STOP2;
                    end else begin
                        w_complete = 1'b1;
                        w_next     = w_brk_final ? ST_BRK_WAIT : ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (w_bit_done) begin
                    w_complete = 1'b1;
                    w_next     = w_brk_final ? ST_BRK_WAIT : ST_IDLE;
                end
            end
            ST_BRK_WAIT: begin
                if (w_sync_si)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk_16x or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge baud_clk_16x or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= 4'd0;
            r_par_en   <= 1'b0;
            r_par_mode <= 2'b00;
            r_two_stop <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_data     <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_all_zero <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_data  <= '0;
            fifo_stat  <= 3'b000;
            overrun    <= 1'b0;
        end else begin
            fifo_wr <= 1'b0;
            overrun <= 1'b0;
            if (w_start) begin
                r_len      <= clamp_len(cfg_data_len, 4'(DW_MAX));
                r_par_en   <= cfg_parity[2];
                r_par_mode <= cfg_parity[1:0];
                r_two_stop <= cfg_stop_bit;
                r_bit_cnt  <= 4'd0;
                r_data     <= '0;
                r_par_err  <= 1'b0;
                r_frm_err  <= 1'b0;
                r_all_zero <= 1'b1;
            end else if (w_bit_done) begin
                case (r_state)
                    ST_DATA: begin
                        r_data     <= r_data | (DW_MAX'(w_bit_val) << r_bit_cnt);
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        r_all_zero <= r_all_zero & ~w_bit_val;
                    end
                    ST_PARITY: begin
                        r_par_err  <= (w_bit_val != w_exp_par);
                        r_all_zero <= r_all_zero & ~w_bit_val;
                    end
                    ST_STOP1, ST_STOP2: begin
                        r_frm_err  <= w_frm_final;
                        r_all_zero <= w_brk_final;
                    end
                    default: ;
                endcase
                // Dropped characters leave the last written data/status untouched.
                if (w_complete) begin
                    if (fifo_aval) begin
                        fifo_wr                <= 1'b1;
                        fifo_data              <= r_data;
                        fifo_stat[c_stat_brk]  <= w_brk_final;
                        fifo_stat[c_stat_frm]  <= w_frm_final;
                        fifo_stat[c_stat_par]  <= r_par_err;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Brief    : Scoreboard bench for uart_rx_core with directed and random frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int DW_MAX      = 9;
    localparam int SYNC_STAGES = 2;

    logic              baud_clk_16x = 1'b0;
    logic              reset_n;
    logic              cfg_rx_enable;
    logic [3:0]        cfg_data_len;
    logic [2:0]        cfg_parity;
    logic              cfg_stop_bit;
    logic              si;
    logic              fifo_aval;
    logic              fifo_wr;
    logic [DW_MAX-1:0] fifo_data;
    logic [2:0]        fifo_stat;
    logic              overrun;
    logic              rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit                ovr;
        logic [DW_MAX-1:0] data;
        logic [2:0]        stat;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    uart_rx_core #(.DW_MAX(DW_MAX), .SYNC_STAGES(SYNC_STAGES)) dut (
        .baud_clk_16x  (baud_clk_16x),
        .reset_n       (reset_n),
        .cfg_rx_enable (cfg_rx_enable),
        .cfg_data_len  (cfg_data_len),
        .cfg_parity    (cfg_parity),
        .cfg_stop_bit  (cfg_stop_bit),
        .si            (si),
        .fifo_aval     (fifo_aval),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .fifo_stat     (fifo_stat),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    always #5 baud_clk_16x = ~baud_clk_16x;
    always @(posedge baud_clk_16x) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge baud_clk_16x);
            #1;
        end
    endtask

    // Monitor: every strobe from the DUT must match the oldest expectation.
    always @(negedge baud_clk_16x) begin
        exp_t e;
        if (reset_n === 1'b1 && (fifo_wr === 1'b1 || overrun === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, fifo_wr, overrun}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                if (e.ovr) begin
                    check("overrun_pulse", {30'd0, overrun, fifo_wr}, 32'h2);
                end else begin
                    check("write_pulse", {30'd0, fifo_wr, overrun}, 32'h2);
                    check("fifo_data", fifo_data, e.data);
                    check("fifo_stat", fifo_stat, e.stat);
                end
            end
        end
    end

    // Builds the line waveform from the character rules, predicts the result, drives it.
    task automatic send_frame(input logic [8:0] data, input logic [3:0] len, input logic [2:0] par,
                              input bit two, input bit flip, input bit stop1_bad, input bit scramble);
        int   n_eff, n0, ref_p, sent_p;
        bit   b[$];
        bit   brk, frm;
        exp_t e;
        n_eff = (len < 5) ? 5 : (len > DW_MAX) ? DW_MAX : int'(len);
        e.data = '0;
        for (int i = 0; i < n_eff; i++) e.data[i] = data[i];
        case (par[1:0])
            2'b00:   ref_p = $countones(e.data) % 2;
            2'b01:   ref_p = 1 - ($countones(e.data) % 2);
            2'b10:   ref_p = 1;
            default: ref_p = 0;
        endcase
        sent_p = flip ? 1 - ref_p : ref_p;
        b.push_back(1'b0);
        for (int i = 0; i < n_eff; i++) b.push_back(e.data[i]);
        if (par[2]) b.push_back(sent_p[0]);
        if (two) begin
            b.push_back(!stop1_bad);
            b.push_back(1'b1);
        end else begin
            b.push_back(1'b1);
        end
        brk = 1'b1;
        for (int i = 1; i < b.size(); i++) if (b[i]) brk = 1'b0;
        frm = (b[b.size()-1] == 1'b0) || (two && b[b.size()-2] == 1'b0);
        e.stat = {brk, frm, par[2] && (sent_p != ref_p)};
        e.ovr  = !fifo_aval;
        cfg_rx_enable = 1'b1;
        cfg_data_len  = len;
        cfg_parity    = par;
        cfg_stop_bit  = two;
        n0 = cyc;
        e.cyc = n0 + SYNC_STAGES + 16 * (b.size() - 1) + 10;
        sb.push_back(e);
        for (int k = 0; k < b.size(); k++) begin
            si = b[k];
            if (k == 1 && scramble) begin
                cfg_data_len  = 4'($urandom);
                cfg_parity    = 3'($urandom);
                cfg_stop_bit  = 1'($urandom);
                cfg_rx_enable = 1'($urandom);
            end
            step(16);
        end
    endtask

    initial begin
        exp_t e;
        int   n0;
        reset_n       = 1'b0;
        si            = 1'b1;
        fifo_aval     = 1'b1;
        cfg_rx_enable = 1'b1;
        cfg_data_len  = 4'd8;
        cfg_parity    = 3'b000;
        cfg_stop_bit  = 1'b0;
        step(3);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_fifo_stat", fifo_stat, 0);
        reset_n = 1'b1;
        step(5);

        // 8N1 0xA5, then 7O2 0x41 with bad then good parity.
        send_frame(9'h0A5, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4);
        send_frame(9'h041, 4'd7, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(9'h041, 4'd7, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4);

        // Short glitch must be rejected as a false start.
        si = 1'b0;
        n0 = cyc;
        step(5);
        si = 1'b1;
        while (cyc < n0 + SYNC_STAGES + 1) step(1);
        check("glitch_busy_t1", rx_busy, 1);
        while (cyc < n0 + SYNC_STAGES + 10) step(1);
        check("glitch_idle_t10", rx_busy, 0);
        step(20);

        // Break: line low for two 8N1 frame times.
        cfg_data_len = 4'd8;
        cfg_parity   = 3'b000;
        cfg_stop_bit = 1'b0;
        e.ovr  = 1'b0;
        e.data = '0;
        e.stat = 3'b110;
        n0 = cyc;
        e.cyc = n0 + SYNC_STAGES + 16 * 9 + 10;
        sb.push_back(e);
        si = 1'b0;
        step(320);
        check("brk_wait_busy", rx_busy, 1);
        si = 1'b1;
        step(5);
        check("brk_released_idle", rx_busy, 0);
        step(10);
        send_frame(9'h055, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun followed by a back-to-back frame.
        fifo_aval = 1'b0;
        send_frame(9'h05A, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_aval = 1'b1;
        send_frame(9'h03C, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4);

        // Reset during data bit 3 discards the partial character.
        si = 1'b0; step(16);
        si = 1'b1; step(16);
        si = 1'b1; step(16);
        si = 1'b0; step(16);
        step(8);
        check("pre_reset_busy", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_fifo_wr", fifo_wr, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_rx_busy", rx_busy, 0);
        check("mid_rst_fifo_data", fifo_data, 0);
        check("mid_rst_fifo_stat", fifo_stat, 0);
        si = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(20);
        send_frame(9'h0FF, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised frames, including clamped lengths and mid-frame config churn.
        for (int i = 0; i < 24; i++) begin
            bit two;
            two = 1'($urandom);
            fifo_aval = ($urandom % 5) != 0;
            send_frame(9'($urandom), 4'($urandom_range(3, 11)), 3'($urandom), two,
                       1'($urandom), two && ($urandom % 4 == 0), 1'($urandom));
            si = 1'b1;
            step($urandom_range(0, 12));
        end
        fifo_aval = 1'b1;
        step(40);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
